// File: rtl/booth_mult_pkg.sv
// Shared types and width helpers for the radix-2 Booth unsigned multiplier.
package booth_mult_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_e;

   // Internal Booth width: one zero MSB keeps unsigned operands non-negative.
   function automatic int unsigned ext_width(input int unsigned data_width);
      return data_width + 1;
   endfunction

   // Counter must hold the value W = data_width + 1.
   function automatic int unsigned cnt_width(input int unsigned data_width);
      return $clog2(data_width + 2);
   endfunction

endpackage

// File: rtl/booth_step.sv
// One combinational radix-2 Booth step: add/sub/no-op on P_hi, then arithmetic shift of {P_hi, Q, q_-1}.
module booth_step #(
   parameter int unsigned W = 9
) (
   input  logic [W-1:0] p_hi_i,
   input  logic [W-1:0] q_i,
   input  logic         q_m1_i,
   input  logic [W-1:0] m_i,
   output logic [W-1:0] p_hi_o,
   output logic [W-1:0] q_o,
   output logic         q_m1_o
);

   logic [W:0] sum;

   // One guard bit so the shifted-in sign is correct even if the add wraps W bits.
   always_comb begin
      sum = {p_hi_i[W-1], p_hi_i};
      case ({q_i[0], q_m1_i})
         2'b10:   sum = {p_hi_i[W-1], p_hi_i} - {1'b0, m_i};
         2'b01:   sum = {p_hi_i[W-1], p_hi_i} + {1'b0, m_i};
         default: sum = {p_hi_i[W-1], p_hi_i};
      endcase
      p_hi_o = sum[W:1];
      q_o    = {sum[0], q_i[W-1:1]};
      q_m1_o = q_i[0];
   end

endmodule

// File: rtl/booth_mult_unsigned.sv
// Sequential unsigned multiplier, one radix-2 Booth step per clock, level enable / done handshake.
// Optional BOOTH_ZERO_SKIP_EN: a zero operand completes in one cycle with product 0.
module booth_mult_unsigned #(
   parameter int unsigned DATA_WIDTH = 8
) (
   input  logic                      clk_i_mult,
   input  logic                      rstn_i_mult,
   input  logic                      en_i_mult,
   input  logic [DATA_WIDTH-1:0]     A,
   input  logic [DATA_WIDTH-1:0]     B,
   output logic [2*DATA_WIDTH-1:0]   result_o,
   output logic                      mult_done_o
);

   import booth_mult_pkg::*;

   localparam int unsigned W  = ext_width(DATA_WIDTH);
   localparam int unsigned CW = cnt_width(DATA_WIDTH);
   localparam int unsigned RW = 2 * DATA_WIDTH;

   state_e          state_q, state_d;
   logic [W-1:0]    p_hi_q, p_hi_d;
   logic [W-1:0]    q_q, q_d;
   logic            q_m1_q, q_m1_d;
   logic [W-1:0]    m_q, m_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [RW-1:0]   result_q, result_d;
   logic            done_q, done_d;

   logic [W-1:0]    step_p;
   logic [W-1:0]    step_q;
   logic            step_qm1;

   booth_step #(.W(W)) u_step (
      .p_hi_i (p_hi_q),
      .q_i    (q_q),
      .q_m1_i (q_m1_q),
      .m_i    (m_q),
      .p_hi_o (step_p),
      .q_o    (step_q),
      .q_m1_o (step_qm1)
   );

   // Next-state and datapath control.
   always_comb begin
      state_d  = state_q;
      p_hi_d   = p_hi_q;
      q_d      = q_q;
      q_m1_d   = q_m1_q;
      m_d      = m_q;
      cnt_d    = cnt_q;
      result_d = result_q;
      done_d   = 1'b0;
      case (state_q)
         IDLE: begin
            if (en_i_mult) begin
               state_d = CALC;
               m_d     = {1'b0, A};
               p_hi_d  = '0;
               q_d     = {1'b0, B};
               q_m1_d  = 1'b0;
               cnt_d   = CW'(W);
`ifdef BOOTH_ZERO_SKIP_EN
               if ((A == '0) || (B == '0)) begin
                  state_d  = DONE;
                  result_d = '0;
               end
`endif
            end
         end
         CALC: begin
            if (!en_i_mult) begin
               state_d = IDLE;
            end else begin
               p_hi_d = step_p;
               q_d    = step_q;
               q_m1_d = step_qm1;
               cnt_d  = cnt_q - CW'(1);
               if (cnt_q == CW'(1)) begin
                  state_d  = DONE;
                  result_d = RW'({step_p, step_q});
               end
            end
         end
         DONE: begin
            if (en_i_mult) begin
               done_d = 1'b1;
            end else begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i_mult or negedge rstn_i_mult) begin
      if (!rstn_i_mult) begin
         state_q  <= IDLE;
         p_hi_q   <= '0;
         q_q      <= '0;
         q_m1_q   <= 1'b0;
         m_q      <= '0;
         cnt_q    <= '0;
         result_q <= '0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         p_hi_q   <= p_hi_d;
         q_q      <= q_d;
         q_m1_q   <= q_m1_d;
         m_q      <= m_d;
         cnt_q    <= cnt_d;
         result_q <= result_d;
         done_q   <= done_d;
      end
   end

   assign result_o    = result_q;
   assign mult_done_o = done_q;

endmodule

// File: tb/tb_booth_mult_unsigned.sv
// Directed and swept checks for booth_mult_unsigned (DATA_WIDTH = 8), with or without BOOTH_ZERO_SKIP_EN.
module tb_booth_mult_unsigned;

   logic        clk;
   logic        rstn;
   logic        en;
   logic [7:0]  a;
   logic [7:0]  b;
   logic [15:0] result;
   logic        done;

   int n_total = 0;
   int n_pass  = 0;

   booth_mult_unsigned #(.DATA_WIDTH(8)) dut (
      .clk_i_mult  (clk),
      .rstn_i_mult (rstn),
      .en_i_mult   (en),
      .A           (a),
      .B           (b),
      .result_o    (result),
      .mult_done_o (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
   endtask

   function automatic int exp_latency(input logic [7:0] x, input logic [7:0] y);
`ifdef BOOTH_ZERO_SKIP_EN
      if (x == 8'd0 || y == 8'd0) return 1;
`endif
      return 10;
   endfunction

   // Full handshake: raise en, count edges to done, check product, drop en, check done clears.
   task automatic run_mult(input string tag, input logic [7:0] x, input logic [7:0] y,
                           input logic [15:0] exp_res);
      int  n;
      bit  got;
      n   = 0;
      got = 1'b0;
      a   = x;
      b   = y;
      en  = 1'b1;
      @(posedge clk);
      while (n < 40 && !got) begin
         @(posedge clk);
         #1;
         n++;
         got = done;
      end
      check({tag, " latency"}, 32'(n), 32'(exp_latency(x, y)));
      check({tag, " result"}, 32'(result), 32'(exp_res));
      en = 1'b0;
      @(posedge clk);
      #1;
      check({tag, " done clear"}, 32'(done), 32'd0);
      @(posedge clk);
      #1;
   endtask

   initial begin
      bit          seen;
      logic [15:0] prev;
      logic [7:0]  rx;
      logic [7:0]  ry;
      rstn = 1'b0;
      en   = 1'b0;
      a    = '0;
      b    = '0;
      #12;
      check("reset result", 32'(result), 32'd0);
      check("reset done", 32'(done), 32'd0);
      #8;
      rstn = 1'b1;

      run_mult("3x5", 8'd3, 8'd5, 16'd15);
      @(posedge clk);
      #1;
      run_mult("7x9", 8'd7, 8'd9, 16'd63);
      run_mult("255x1", 8'd255, 8'd1, 16'd255);
      run_mult("255x0", 8'd255, 8'd0, 16'd0);
      run_mult("0x255", 8'd0, 8'd255, 16'd0);
      run_mult("255x254", 8'd255, 8'd254, 16'd64770);
      run_mult("255x255", 8'd255, 8'd255, 16'd65025);

      // Abort mid-calculation; operands changed after capture must also be ignored.
      prev = result;
      a    = 8'd12;
      b    = 8'd12;
      en   = 1'b1;
      @(posedge clk);
      a = 8'd99;
      b = 8'd77;
      repeat (4) @(posedge clk);
      #1;
      en   = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < 15; i++) begin
         @(posedge clk);
         #1;
         if (done) seen = 1'b1;
      end
      check("abort no done", 32'(seen), 32'd0);
      check("abort result held", 32'(result), 32'(prev));
      run_mult("12x12 restart", 8'd12, 8'd12, 16'd144);

      // Asynchronous reset mid-calculation.
      a  = 8'd200;
      b  = 8'd100;
      en = 1'b1;
      repeat (4) @(posedge clk);
      #2;
      rstn = 1'b0;
      #1;
      check("async rst result", 32'(result), 32'd0);
      check("async rst done", 32'(done), 32'd0);
      en = 1'b0;
      @(negedge clk);
      rstn = 1'b1;
      @(posedge clk);
      #1;
      check("post rst done", 32'(done), 32'd0);
      run_mult("200x100", 8'd200, 8'd100, 16'd20000);

      for (int i = 0; i < 1000; i++) begin
         rx = 8'($urandom_range(0, 255));
         ry = 8'($urandom_range(0, 255));
         if (i == 0) rx = 8'd0;
         run_mult("sweep", rx, ry, 16'(rx) * 16'(ry));
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks done", n_pass, n_total);
      $fatal(1, "watchdog");
   end

endmodule
